dmem_io_arbiter: RTL and testbench

- Shares the single-ported data memory / memory-mapped IO bus between two requesters.
- Requester 0 is the CPU MEM stage; requester 1 is the debug/IO port (switch/hex-display service path).
- Serialises accesses, applies a fixed memory read latency, returns read data with a one-cycle ack, and drives a stall to the pipeline while the CPU waits.

---
 rtl/dmem_io_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_io_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_arbiter.sv
// Arbiter between the CPU MEM stage and the debug/IO port for the shared data memory / MMIO bus.
// Build option: define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU priority (default is round-robin).
module dmem_io_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic       OWN_CPU = 1'b0;
   localparam logic       OWN_DBG = 1'b1;
   localparam logic [2:0] LAT     = 3'(MEM_LAT);

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          last_owner_q, last_owner_d;
   logic          acc_we_q, acc_we_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          dbg_ack_q, dbg_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
   logic          grant_dbg;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
   assign grant_dbg = dbg_req & ~cpu_req;
`else
   // On a tie the debug port wins only if the CPU was served last.
   assign grant_dbg = dbg_req & (~cpu_req | (last_owner_q == OWN_CPU));
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      acc_we_d     = acc_we_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_ack_d    = 1'b0;
      dbg_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req | dbg_req) begin
               owner_d     = grant_dbg ? OWN_DBG : OWN_CPU;
               acc_we_d    = grant_dbg ? dbg_we : cpu_we;
               mem_addr_d  = grant_dbg ? dbg_addr : cpu_addr;
               mem_wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
               mem_we_d    = acc_we_d;
               mem_en_d    = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = LAT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_RESP;
               if (!acc_we_q) begin
                  if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata;
                  else                    cpu_rdata_d = mem_rdata;
               end
               if (owner_q == OWN_DBG) dbg_ack_d = 1'b1;
               else                    cpu_ack_d = 1'b1;
            end
         end
         S_RESP: begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_DBG;
         acc_we_q     <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dbg_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         acc_we_q     <= acc_we_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dbg_ack_q    <= dbg_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_ack_q;
   assign dbg_stall = dbg_req & ~dbg_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Bench for dmem_io_arbiter: transaction-level timing model plus small word memory.
`timescale 1ns/1ps
module tb_dmem_io_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ack, cpu_stall;
   logic [DW-1:0] cpu_rdata;
   logic          dbg_req = 1'b0, dbg_we = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          dbg_ack, dbg_stall;
   logic [DW-1:0] dbg_rdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [31:0] env_mem [16];
   assign mem_rdata = env_mem[mem_addr[5:2]];

   dmem_io_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_stall(dbg_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int e = 0;

   // Reference model: one access at a time, timed purely from the grant edge.
   bit          m_active = 1'b0;
   int          m_issue = 0, m_ack = 0, m_next = 0;
   bit          m_owner = 1'b0, m_we = 1'b0, m_last = 1'b1;
   logic [31:0] m_addr = '0, m_wdata = '0, m_pend = '0;
   logic [31:0] m_mem [16];
   logic [31:0] exp_rd [2];
   bit          exp_ack [2];
   bit          rr_phase = 1'b0, have_prev = 1'b0, prev_dbg = 1'b0;
   logic [31:0] prior;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_last   = 1'b1;
      m_next   = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_ack[0] = 1'b0;
      exp_ack[1] = 1'b0;
   endtask

   task automatic model_edge();
      bit w;
      if (m_active && e == m_ack + 1) m_active = 1'b0;
      if (!m_active && e >= m_next && (cpu_req || dbg_req)) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
         w = cpu_req ? 1'b0 : 1'b1;
`else
         if (cpu_req && dbg_req) w = ~m_last;
         else                    w = cpu_req ? 1'b0 : 1'b1;
`endif
         m_last   = w;
         m_owner  = w;
         m_we     = w ? dbg_we : cpu_we;
         m_addr   = w ? dbg_addr : cpu_addr;
         m_wdata  = w ? dbg_wdata : cpu_wdata;
         m_active = 1'b1;
         m_issue  = e;
         m_ack    = e + 1 + LAT;
         m_next   = e + LAT + 3;
         if (m_we) m_mem[m_addr[5:2]] = m_wdata;
         else      m_pend = m_mem[m_addr[5:2]];
      end
      if (m_active && e == m_ack && !m_we) exp_rd[m_owner] = m_pend;
   endtask

   task automatic check();
      bit en_exp, ack_now;
      en_exp  = m_active && (e == m_issue);
      ack_now = m_active && (e == m_ack);
      exp_ack[0] = ack_now && !m_owner;
      exp_ack[1] = ack_now && m_owner;
      chk("mem_en", 64'(mem_en), 64'(en_exp));
      chk("mem_we", 64'(mem_we), 64'(en_exp && m_we));
      if (en_exp) begin
         chk("mem_addr", 64'(mem_addr), 64'(m_addr));
         chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      chk("cpu_ack", 64'(cpu_ack), 64'(exp_ack[0]));
      chk("dbg_ack", 64'(dbg_ack), 64'(exp_ack[1]));
      chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_rd[0]));
      chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_rd[1]));
      chk("busy", 64'(busy), 64'(m_active));
      chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !exp_ack[0]));
      chk("dbg_stall", 64'(dbg_stall), 64'(dbg_req && !exp_ack[1]));
      if (mem_en && mem_we) env_mem[mem_addr[5:2]] = mem_wdata;
      if (rr_phase && (cpu_ack || dbg_ack)) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
         chk("prio_cpu_only", 64'(dbg_ack), 64'd0);
`else
         if (have_prev) chk("rr_alternate", 64'(dbg_ack), 64'(!prev_dbg));
         prev_dbg  = dbg_ack;
         have_prev = 1'b1;
`endif
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      e++;
      model_edge();
      #1;
      check();
      @(negedge clock);
   endtask

   // Requesters hold their fields until acked, then optionally issue a new access.
   task automatic gen(input int pc, input int pd);
      if (exp_ack[0] || !cpu_req) begin
         if ($urandom_range(99) < pc) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = $urandom; cpu_wdata = $urandom;
         end else cpu_req = 1'b0;
      end
      if (exp_ack[1] || !dbg_req) begin
         if ($urandom_range(99) < pd) begin
            dbg_req = 1'b1; dbg_we = 1'($urandom_range(1));
            dbg_addr = $urandom; dbg_wdata = $urandom;
         end else dbg_req = 1'b0;
      end
   endtask

   task automatic run_until_ack(input int r);
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (exp_ack[r]) break;
      end
      chk("ack_seen", 64'(r == 1 ? dbg_ack : cpu_ack), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = $urandom;
         m_mem[i]   = env_mem[i];
      end
      model_reset();
      @(posedge clock);
      #1;
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
      chk("rst_dbg_ack", 64'(dbg_ack), 64'd0);
      chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Directed CPU read of 0x10
      env_mem[4] = 32'hDEADBEEF;
      m_mem[4]   = 32'hDEADBEEF;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
      run_until_ack(0);
      chk("dir_rd_data", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
      cpu_req = 1'b0;
      repeat (2) cycle();

      // Directed debug write of 0x5 to 0x20
      prior = exp_rd[1];
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h5;
      run_until_ack(1);
      chk("dbg_wr_keep", 64'(dbg_rdata), 64'(prior));
      dbg_req = 1'b0;
      repeat (2) cycle();
      chk("dbg_wr_mem", 64'(env_mem[8]), 64'd5);

      // Both requesters held continuously
      rr_phase = 1'b1;
      repeat (40) begin gen(100, 100); cycle(); end
      rr_phase = 1'b0;
      repeat (12) begin gen(0, 100); cycle(); end
      repeat (16) begin gen(0, 0); cycle(); end

      // Random traffic
      repeat (400) begin gen(35, 35); cycle(); end
      repeat (16) begin gen(0, 0); cycle(); end

      // Reset in the middle of a CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
      for (int i = 0; i < 10 && !(m_active && e == m_issue + 1); i++) cycle();
      reset = 1'b1;
      #1;
      chk("rstw_mem_en", 64'(mem_en), 64'd0);
      chk("rstw_cpu_ack", 64'(cpu_ack), 64'd0);
      chk("rstw_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("rstw_busy", 64'(busy), 64'd0);
      model_reset();
      cpu_req = 1'b0;
      @(posedge clock);
      e++;
      @(negedge clock);
      reset = 1'b0;
      repeat (8) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
